// File: rtl/memory_writeback_stage.sv
// memory_writeback_stage
// Memory and writeback end of the five-stage RISC-V pipeline: EX/MEM register, data memory,
// MEM/WB register and the final result select.
//
// Optional feature macro: DMEM_BYTE_EN (sub-word loads/stores; default build is word-only).
//
// Ports:
//   clk, rst (async, active-low)
//   RegWriteE, ResultSrcE, MemWriteE, Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E : E inputs
//   ALUResultM, RdM, RegWriteM : memory-stage outputs for forwarding/hazard logic
//   ResultW, RdW, RegWriteW    : register-file write port
module memory_writeback_stage #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = $clog2(DMEM_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic        MemWriteE,
    input  logic [2:0]  Funct3E,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    input  logic [31:0] PCPlus4E,
    output logic [31:0] ALUResultM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW
);

    // EX/MEM register
    logic        reg_write_m_q;
    logic [1:0]  result_src_m_q;
    logic        mem_write_m_q;
    logic [31:0] alu_result_m_q;
    logic [31:0] write_data_m_q;
    logic [4:0]  rd_m_q;
    logic [31:0] pc_plus4_m_q;
`ifdef DMEM_BYTE_EN
    logic [2:0]  funct3_m_q;
`else
    logic        unused_funct3;
    assign unused_funct3 = ^Funct3E;
`endif

    // MEM/WB register
    logic        reg_write_w_q;
    logic [1:0]  result_src_w_q;
    logic [31:0] alu_result_w_q;
    logic [31:0] read_data_w_q;
    logic [4:0]  rd_w_q;
    logic [31:0] pc_plus4_w_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m_q  <= 1'b0;
            result_src_m_q <= 2'b00;
            mem_write_m_q  <= 1'b0;
            alu_result_m_q <= 32'h0;
            write_data_m_q <= 32'h0;
            rd_m_q         <= 5'd0;
            pc_plus4_m_q   <= 32'h0;
`ifdef DMEM_BYTE_EN
            funct3_m_q     <= 3'b000;
`endif
        end else begin
            reg_write_m_q  <= RegWriteE;
            result_src_m_q <= ResultSrcE;
            mem_write_m_q  <= MemWriteE;
            alu_result_m_q <= ALUResultE;
            write_data_m_q <= WriteDataE;
            rd_m_q         <= RdE;
            pc_plus4_m_q   <= PCPlus4E;
`ifdef DMEM_BYTE_EN
            funct3_m_q     <= Funct3E;
`endif
        end
    end

    assign ALUResultM = alu_result_m_q;
    assign RdM        = rd_m_q;
    // Writes to x0 are squashed here so nothing downstream needs to care.
    assign RegWriteM  = reg_write_m_q && (rd_m_q != 5'd0);

    // Data memory; upper address bits are ignored so accesses wrap modulo 4*DMEM_DEPTH.
    logic [31:0]        dmem [DMEM_DEPTH];
    logic [DMEM_AW-1:0] dmem_idx;
    logic [31:0]        rd_word;
    logic [31:0]        load_data;

    assign dmem_idx = alu_result_m_q[DMEM_AW+1:2];
    assign rd_word  = dmem[dmem_idx];

`ifdef DMEM_BYTE_EN
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rd_word[{alu_result_m_q[1:0], 3'b000} +: 8];
        lane_half = alu_result_m_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_m_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated into every lane; the byte enables pick which lanes land.
    always_comb begin
        case (funct3_m_q)
            3'b000: begin
                store_be   = 4'b0001 << alu_result_m_q[1:0];
                store_data = {4{write_data_m_q[7:0]}};
            end
            3'b001: begin
                store_be   = alu_result_m_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{write_data_m_q[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = write_data_m_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_write_m_q) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) begin
                    dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end
`else
    assign load_data = rd_word;

    always_ff @(posedge clk) begin
        if (mem_write_m_q) begin
            dmem[dmem_idx] <= write_data_m_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 2'b00;
            alu_result_w_q <= 32'h0;
            read_data_w_q  <= 32'h0;
            rd_w_q         <= 5'd0;
            pc_plus4_w_q   <= 32'h0;
        end else begin
            reg_write_w_q  <= RegWriteM;
            result_src_w_q <= result_src_m_q;
            alu_result_w_q <= alu_result_m_q;
            read_data_w_q  <= load_data;
            rd_w_q         <= rd_m_q;
            pc_plus4_w_q   <= pc_plus4_m_q;
        end
    end

    assign RdW       = rd_w_q;
    assign RegWriteW = reg_write_w_q && (rd_w_q != 5'd0);

    always_comb begin
        case (result_src_w_q)
            2'b00:   ResultW = alu_result_w_q;
            2'b01:   ResultW = read_data_w_q;
            2'b10:   ResultW = pc_plus4_w_q;
            default: ResultW = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Self-checking bench for memory_writeback_stage: a table of per-cycle vectors (inputs plus
// the M-stage and W-stage outputs expected after that cycle's rising edge), followed by
// hand-written sequences for reset behaviour.
module tb_memory_writeback_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [4:0]  RdE;
    logic [31:0] PCPlus4E;
    logic [31:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;

    memory_writeback_stage #(
        .DMEM_DEPTH(1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteE (RegWriteE),
        .ResultSrcE(ResultSrcE),
        .MemWriteE (MemWriteE),
        .Funct3E   (Funct3E),
        .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE),
        .RdE       (RdE),
        .PCPlus4E  (PCPlus4E),
        .ALUResultM(ALUResultM),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .ResultW   (ResultW),
        .RdW       (RdW),
        .RegWriteW (RegWriteW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] e_alum;
        logic [4:0]  e_rdm;
        logic        e_rwm;
        logic [31:0] e_resw;
        logic [4:0]  e_rdw;
        logic        e_rww;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic rw, input logic [1:0] src, input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] e_alum, input logic [4:0] e_rdm,
                       input logic e_rwm, input logic [31:0] e_resw, input logic [4:0] e_rdw,
                       input logic e_rww);
        vec_t v;
        v.rw = rw; v.src = src; v.mw = mw; v.f3 = f3; v.alu = alu; v.wd = wd; v.rd = rd;
        v.pc = pc; v.e_alum = e_alum; v.e_rdm = e_rdm; v.e_rwm = e_rwm; v.e_resw = e_resw;
        v.e_rdw = e_rdw; v.e_rww = e_rww;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc);
        RegWriteE = rw; ResultSrcE = src; MemWriteE = mw; Funct3E = f3;
        ALUResultE = alu; WriteDataE = wd; RdE = rd; PCPlus4E = pc;
    endtask

    task automatic bubble();
        drive(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    initial begin
        // rw src mw f3 alu wd rd pc | M: alu rd rw | W: result rd rw
        add(1, 2'b00, 0, 3'b010, 32'h1234_5678, 32'h0, 5'd5, 32'h0,
            32'h1234_5678, 5'd5, 1, 32'h0, 5'd0, 0);
        add(1, 2'b00, 0, 3'b010, 32'hAAAA_0001, 32'h0, 5'd0, 32'h0,
            32'hAAAA_0001, 5'd0, 0, 32'h1234_5678, 5'd5, 1);
        add(0, 2'b00, 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0, 32'h0,
            32'h0000_0040, 5'd0, 0, 32'hAAAA_0001, 5'd0, 0);
        add(1, 2'b01, 0, 3'b010, 32'h0000_0040, 32'h0, 5'd7, 32'h0,
            32'h0000_0040, 5'd7, 1, 32'h0000_0040, 5'd0, 0);
        add(1, 2'b01, 0, 3'b010, 32'h0000_1040, 32'h0, 5'd8, 32'h0,
            32'h0000_1040, 5'd8, 1, 32'hDEAD_BEEF, 5'd7, 1);
        add(1, 2'b10, 0, 3'b010, 32'h0000_0055, 32'h0, 5'd1, 32'h104,
            32'h0000_0055, 5'd1, 1, 32'hDEAD_BEEF, 5'd8, 1);
        add(1, 2'b11, 0, 3'b010, 32'h0000_0077, 32'h0, 5'd2, 32'h200,
            32'h0000_0077, 5'd2, 1, 32'h0000_0104, 5'd1, 1);
        add(0, 2'b00, 0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0,
            32'h0, 5'd0, 0, 32'h0, 5'd2, 1);
        add(0, 2'b00, 0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0,
            32'h0, 5'd0, 0, 32'h0, 5'd0, 0);
`ifdef DMEM_BYTE_EN
        add(0, 2'b00, 1, 3'b010, 32'h10, 32'h8070_60F0, 5'd0, 32'h0,
            32'h10, 5'd0, 0, 32'h0, 5'd0, 0);
        add(0, 2'b00, 1, 3'b000, 32'h11, 32'h0000_00AA, 5'd0, 32'h0,
            32'h11, 5'd0, 0, 32'h10, 5'd0, 0);
        add(1, 2'b01, 0, 3'b000, 32'h11, 32'h0, 5'd9, 32'h0,
            32'h11, 5'd9, 1, 32'h11, 5'd0, 0);
        add(1, 2'b01, 0, 3'b100, 32'h11, 32'h0, 5'd10, 32'h0,
            32'h11, 5'd10, 1, 32'hFFFF_FFAA, 5'd9, 1);
        add(1, 2'b01, 0, 3'b001, 32'h12, 32'h0, 5'd11, 32'h0,
            32'h12, 5'd11, 1, 32'h0000_00AA, 5'd10, 1);
        add(1, 2'b01, 0, 3'b010, 32'h10, 32'h0, 5'd12, 32'h0,
            32'h10, 5'd12, 1, 32'hFFFF_8070, 5'd11, 1);
        add(1, 2'b01, 0, 3'b101, 32'h12, 32'h0, 5'd13, 32'h0,
            32'h12, 5'd13, 1, 32'h8070_AAF0, 5'd12, 1);
        add(0, 2'b00, 0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0,
            32'h0, 5'd0, 0, 32'h0000_8070, 5'd13, 1);
`endif

        // Reset held with toggling inputs: all outputs must stay zero.
        rst = 1'b0;
        bubble();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom),
                  $urandom, $urandom, 5'($urandom_range(1, 31)), $urandom);
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d ALUResultM", c), ALUResultM, 32'h0);
            chk($sformatf("rst%0d RdM", c), 32'(RdM), 32'h0);
            chk($sformatf("rst%0d RegWriteM", c), 32'(RegWriteM), 32'h0);
            chk($sformatf("rst%0d ResultW", c), ResultW, 32'h0);
            chk($sformatf("rst%0d RdW", c), 32'(RdW), 32'h0);
            chk($sformatf("rst%0d RegWriteW", c), 32'(RegWriteW), 32'h0);
        end
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rw, vecs[i].src, vecs[i].mw, vecs[i].f3, vecs[i].alu, vecs[i].wd,
                  vecs[i].rd, vecs[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d ALUResultM", i), ALUResultM, vecs[i].e_alum);
            chk($sformatf("row%0d RdM", i), 32'(RdM), 32'(vecs[i].e_rdm));
            chk($sformatf("row%0d RegWriteM", i), 32'(RegWriteM), 32'(vecs[i].e_rwm));
            chk($sformatf("row%0d ResultW", i), ResultW, vecs[i].e_resw);
            chk($sformatf("row%0d RdW", i), 32'(RdW), 32'(vecs[i].e_rdw));
            chk($sformatf("row%0d RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].e_rww));
        end

        // A store sitting in M when reset asserts must be dropped; the earlier one survives.
        drive(1'b0, 2'b00, 1'b1, 3'b010, 32'h80, 32'h1111_1111, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 1'b1, 3'b010, 32'h80, 32'h2222_2222, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("pending store in M", ALUResultM, 32'h80);
        bubble();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst ALUResultM", ALUResultM, 32'h0);
        chk("async rst ResultW", ResultW, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h80, 32'h0, 5'd3, 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst RdM", 32'(RdM), 32'd3);
        bubble();
        @(posedge clk);
        #1;
        chk("dropped store ResultW", ResultW, 32'h1111_1111);
        chk("dropped store RdW", 32'(RdW), 32'd3);
        chk("dropped store RegWriteW", 32'(RegWriteW), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_writeback_stage.md
# memory_writeback_stage

Memory and writeback end of the five-stage RISC-V pipeline. It registers the execute-stage results into the EX/MEM register, performs data-memory loads and stores, registers the outcome into the MEM/WB register, and selects the final result. Its outputs `ResultW`, `RdW` and `RegWriteW` drive the register-file write port inside the decode stage. Its memory-stage outputs feed the hazard/forwarding logic.

## Interface
Parameters:
- `DMEM_DEPTH`, default 1024: number of 32-bit data-memory words; must be a power of two.
- `DMEM_AW`, default `$clog2(DMEM_DEPTH)`: word-index width.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `RegWriteE`, input, 1: execute-stage register-write enable.
- `ResultSrcE`, input, 2: result select, 00 ALU, 01 load data, 10 PC+4, 11 zero.
- `MemWriteE`, input, 1: store enable.
- `Funct3E`, input, 3: load/store width code; used only with `DMEM_BYTE_EN`.
- `ALUResultE`, input, 32: ALU result or effective address.
- `WriteDataE`, input, 32: store data (forwarded rs2).
- `RdE`, input, 5: destination register.
- `PCPlus4E`, input, 32: link value.
- `ALUResultM`, output, 32: registered ALU result, for forwarding.
- `RdM`, output, 5: registered destination register.
- `RegWriteM`, output, 1: masked write enable in M.
- `ResultW`, output, 32: writeback value to the register file.
- `RdW`, output, 5: writeback destination register.
- `RegWriteW`, output, 1: masked writeback enable.

## Operation
- EX/MEM register captures every `*E` input on each rising edge. There is no stall or flush input; bubbles arrive from execute as `RegWriteE=0`, `MemWriteE=0`.
- `RegWriteM` is the registered `RegWriteE` AND (`RdM != 0`). `RegWriteW` applies the same mask using `RdW`. Writes to x0 never leave this block.
- Data memory is `DMEM_DEPTH` x 32 bits.
  - Word index is `ALUResultM[DMEM_AW+1:2]`. Higher address bits are ignored, so addresses wrap modulo `4*DMEM_DEPTH`.
  - Reads are combinational from the index.
  - Writes are synchronous at the rising edge that ends the M cycle, when `MemWriteM=1`.
- Memory contents are not reset. Reading a never-written location returns X in simulation.
- MEM/WB register captures `RegWriteM`, `ResultSrcM`, `ALUResultM`, load data (after width/extension handling), `RdM` and `PCPlus4M`.
- `ResultW` is a combinational mux on `ResultSrcW`: 00 `ALUResultW`, 01 `ReadDataW`, 10 `PCPlus4W`, 11 `32'h0`.
- Reset, asserted asynchronously while `rst=0`:
  - All EX/MEM and MEM/WB fields clear to 0.
  - Therefore `ALUResultM=0`, `RdM=0`, `RegWriteM=0`, `ResultW=0`, `RdW=0`, `RegWriteW=0`.
  - A store pending in M at reset assertion is dropped, because `MemWriteM` is cleared before any edge.

## Timing
- Latency from E inputs to M outputs: 1 cycle. From E inputs to `ResultW`/`RdW`/`RegWriteW`: 2 cycles.
- Load: address is in M during cycle n; data is in `ResultW` during cycle n+1.
- Store in M during cycle n to address A, followed by a load of A in M during cycle n+1: the load returns the new data, because the write commits at the edge between the two cycles.
- Same-cycle store and load are impossible (a single M slot).
- `ResultW` is valid combinationally within cycle n+1. The register file must write it at the edge ending that cycle, or on the falling edge per decode-stage convention.
- Reset release: the first capture happens on the first rising edge with `rst=1`.

## Configuration
- `DMEM_BYTE_EN` defined: sub-word accesses are enabled.
  - `Funct3M` selects SB/SH/SW (000/001/010) and LB/LH/LW/LBU/LHU (000/001/010/100/101).
  - Stores use byte-lane write enables. The lane is chosen by `ALUResultM[1:0]` for bytes and `ALUResultM[1]` for halfwords (bit 0 ignored). Store data is replicated into the selected lane.
  - Loads extract the lane in M and sign- or zero-extend it before the MEM/WB register.
  - Undefined `Funct3M` values behave as word accesses.
- `DMEM_BYTE_EN` undefined: word-only access.
  - `Funct3E` is accepted but unused. `ALUResultM[1:0]` are ignored.
  - Stores write all 32 bits; loads return the full word.

## Test plan
- Reset: hold `rst=0` with random E inputs toggling -> all six outputs stay 0. Release `rst` -> `RdM` follows `RdE` one cycle later.
- ALU writeback: `ALUResultE=32'h1234_5678`, `RdE=5`, `RegWriteE=1`, `ResultSrcE=00` -> two cycles later `ResultW=32'h1234_5678`, `RdW=5`, `RegWriteW=1`.
- x0 masking: `RdE=0`, `RegWriteE=1` -> `RegWriteM=0` next cycle and `RegWriteW=0` the cycle after.
- Store then back-to-back load: SW `32'hDEAD_BEEF` to address `0x40`, then LW from `0x40` in the next cycle, `RdE=7` -> `ResultW=32'hDEAD_BEEF`. A load from address `0x40 + 4*DMEM_DEPTH` also returns `32'hDEAD_BEEF` (wrap).
- Link select: `ResultSrcE=10`, `PCPlus4E=32'h104` -> `ResultW=32'h104`. `ResultSrcE=11` -> `ResultW=0`.
- With `DMEM_BYTE_EN`: SW `32'h8070_60F0` to `0x10`, then SB `32'h0000_00AA` to `0x11`.
  - LB `0x11` -> `32'hFFFF_FFAA`.
  - LBU `0x11` -> `32'h0000_00AA`.
  - LH `0x12` -> `32'hFFFF_8070`.
  - LW `0x10` -> `32'h8070_AAF0`.
